// File: rtl/wbr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbr_pkg
// Description : Shared types and constants for the WBR sequencer: FSM state
//               encoding, default chain length and boundary-cell positions.
// Revision    : 1.0 - initial release
// ============================================================================
package wbr_pkg;

    // Default chain length: 6 ADDR + MBISTRUN + MBISTDLOG + RESET
    localparam int c_WBR_LEN = 9;

    // Position of each boundary cell in the chain (index 0 is nearest WPSO)
    localparam int c_CELL_ADDR_LSB  = 0;
    localparam int c_CELL_ADDR_MSB  = 5;
    localparam int c_CELL_MBISTRUN  = 6;
    localparam int c_CELL_MBISTDLOG = 7;
    localparam int c_CELL_RESET     = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_DONE    = 3'd4
    } wbr_state_t;

endpackage
`default_nettype wire

// File: rtl/wbr_ser_des.sv
`default_nettype none
// ============================================================================
// Module      : wbr_ser_des
// Description : Pattern serializer, WPSO deserializer and shift counter for
//               one WBR operation.
// Revision    : 1.0 - initial release
// ============================================================================
module wbr_ser_des
    import wbr_pkg::*;
#(
    parameter int WBR_LEN = c_WBR_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [WBR_LEN-1:0] i_pat,
    input  logic               i_so,
    output logic               o_si,
    output logic [WBR_LEN-1:0] o_result,
    output logic               o_last
);

    localparam int CNT_W = $clog2(WBR_LEN + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WBR_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [WBR_LEN-1:0] r_pat;
    logic [WBR_LEN-1:0] r_result;
    logic [CNT_W-1:0]   r_cnt;

    // Load pattern on start; on each shift edge move both registers one bit
    // toward index 0. Result is left untouched by load so it stays readable
    // until the next operation actually starts shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_pat <= i_pat;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_pat    <= {1'b0, r_pat[WBR_LEN-1:1]};
            r_result <= {i_so, r_result[WBR_LEN-1:1]};
            r_cnt    <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_ONE;
        end
    end

    assign o_si     = r_pat[0];
    assign o_result = r_result;
    assign o_last   = (r_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/wbr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wbr_seq_ctrl
// Description : Sequencer for one IEEE 1500 wrapper boundary register chain.
//               Runs optional CAPTURE, full-length SHIFT, optional UPDATE.
// Revision    : 1.0 - initial release
// ============================================================================
module wbr_seq_ctrl
    import wbr_pkg::*;
#(
    parameter int WBR_LEN = c_WBR_LEN
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic               skip_capture,
    input  logic               skip_update,
    input  logic [WBR_LEN-1:0] pat_in,
    input  logic               WPSO,
    output logic               WPSI,
    output logic               wse_inputs,
    output logic               hold_inputs,
    output logic               capture_en,
    output logic               shift_en,
    output logic               busy,
    output logic               done,
    output logic [WBR_LEN-1:0] result
);

    wbr_state_t r_state;
    wbr_state_t w_state_next;
    logic       r_skip_update;
    logic       w_load;
    logic       w_shift;
    logic       w_last;

    logic r_wse;
    logic r_hold;
    logic r_capture;
    logic r_shift_en;
    logic r_busy;
    logic r_done;

    wbr_ser_des #(
        .WBR_LEN (WBR_LEN)
    ) u_ser_des (
        .clk      (CLK),
        .rst      (RESET),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_pat    (pat_in),
        .i_so     (WPSO),
        .o_si     (WPSI),
        .o_result (result),
        .o_last   (w_last)
    );

    // State register plus the skip_update flag latched at start
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_skip_update <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_skip_update <= skip_update;
            end
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = skip_capture ? ST_SHIFT : ST_CAPTURE;
                end
            end
            ST_CAPTURE: w_state_next = ST_SHIFT;
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_next = r_skip_update ? ST_DONE : ST_UPDATE;
                end
            end
            ST_UPDATE: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the
    // state they belong to and never see a combinational path from start
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wse      <= 1'b0;
            r_hold     <= 1'b1;
            r_capture  <= 1'b0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wse      <= (w_state_next == ST_CAPTURE) || (w_state_next == ST_SHIFT) ||
                          (w_state_next == ST_UPDATE);
            r_hold     <= (w_state_next != ST_UPDATE);
            r_capture  <= (w_state_next == ST_CAPTURE);
            r_shift_en <= (w_state_next == ST_SHIFT);
            r_busy     <= (w_state_next != ST_IDLE);
            r_done     <= (w_state_next == ST_DONE);
        end
    end

    assign wse_inputs  = r_wse;
    assign hold_inputs = r_hold;
    assign capture_en  = r_capture;
    assign shift_en    = r_shift_en;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wbr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbr_seq_ctrl
// Description : Self-checking bench for wbr_seq_ctrl with an operation-level
//               reference model, an ideal WBR chain and directed/random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wbr_seq_ctrl;

    localparam int N = 9;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         start = 1'b0;
    logic         skip_capture = 1'b0;
    logic         skip_update = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic         WPSO;
    logic         WPSI, wse_inputs, hold_inputs, capture_en, shift_en, busy, done;
    logic [N-1:0] result;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    wbr_seq_ctrl #(.WBR_LEN(N)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (start),
        .skip_capture (skip_capture),
        .skip_update  (skip_update),
        .pat_in       (pat_in),
        .WPSO         (WPSO),
        .WPSI         (WPSI),
        .wse_inputs   (wse_inputs),
        .hold_inputs  (hold_inputs),
        .capture_en   (capture_en),
        .shift_en     (shift_en),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    // Ideal WBR chain: shifts toward index 0 whenever shift_en is high
    logic [N-1:0] chain = '0;
    logic [N-1:0] env_val = '0;
    logic         env_load = 1'b0;
    always @(posedge CLK) begin
        if (env_load)      chain <= env_val;
        else if (shift_en) chain <= {WPSI, chain[N-1:1]};
    end
    assign WPSO = chain[0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: an operation is a list of phases built when start is
    // accepted; the model walks that list one cycle at a time.
    typedef enum int {K_IDLE, K_CAP, K_SHIFT, K_UPD, K_DONE} kind_t;
    typedef struct { kind_t kind; int idx; } step_t;

    step_t        q[$];
    step_t        cur = '{K_IDLE, 0};
    logic [N-1:0] m_pat = '0;
    logic [N-1:0] m_snap = '0;
    logic [N-1:0] m_result = '0;
    bit           m_valid = 1'b0;

    always @(posedge CLK) begin
        if (RESET) begin
            q.delete();
            cur = '{K_IDLE, 0};
            m_result = '0;
            m_valid = 1'b1;
        end else begin
            if (cur.kind == K_SHIFT) m_result = {m_snap[cur.idx], m_result[N-1:1]};
            if (cur.kind == K_IDLE && start) begin
                m_pat  = pat_in;
                m_snap = chain;
                if (!skip_capture) q.push_back('{K_CAP, 0});
                for (int k = 0; k < N; k++) q.push_back('{K_SHIFT, k});
                if (!skip_update) q.push_back('{K_UPD, 0});
                q.push_back('{K_DONE, 0});
            end
            if (q.size() > 0) cur = q.pop_front();
            else              cur = '{K_IDLE, 0};
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        logic [5:0] exp_ctl;
        logic [5:0] act_ctl;
        if (m_valid) begin
            exp_ctl = {(cur.kind == K_CAP) || (cur.kind == K_SHIFT) || (cur.kind == K_UPD),
                       cur.kind != K_UPD, cur.kind == K_CAP, cur.kind == K_SHIFT,
                       cur.kind != K_IDLE, cur.kind == K_DONE};
            act_ctl = {wse_inputs, hold_inputs, capture_en, shift_en, busy, done};
            check("ctl{wse,hold,cap,shift,busy,done}", 64'(act_ctl), 64'(exp_ctl));
            check("result", 64'(result), 64'(m_result));
            if (cur.kind == K_SHIFT) check("wpsi", 64'(WPSI), 64'(m_pat[cur.idx]));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: plain, 1: extra start pulse during SHIFT, 2: RESET on 4th SHIFT cycle
    task automatic run_op(input logic [N-1:0] p, input bit sc, input bit su, input int mode,
                          output int lat, output int ncap, output int nsh, output int nupd,
                          output logic [N-1:0] seq);
        pat_in = p; skip_capture = sc; skip_update = su; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0; pat_in = ~p; skip_capture = ~sc; skip_update = ~su;
        lat = 0; ncap = 0; nsh = 0; nupd = 0; seq = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (capture_en) ncap++;
            if (shift_en) begin
                if (nsh < N) seq[nsh] = WPSI;
                nsh++;
            end
            if (!hold_inputs) nupd++;
            if (done) begin
                lat = n;
                break;
            end
            if (mode == 1 && nsh == 3) begin
                start = 1'b1;
                pat_in = N'($urandom);
            end else if (mode == 1) begin
                start = 1'b0;
            end
            if (mode == 2 && nsh == 4) begin
                RESET = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    int           lat, ncap, nsh, nupd, cnt, t_done, t_cap;
    logic [N-1:0] seq;

    initial begin
        // Reset and idle
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        repeat (5) tick();
        @(negedge CLK);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_hold", 64'(hold_inputs), 64'd1);
        check("idle_wpsi", 64'(WPSI), 64'd0);
        check("idle_result", 64'(result), 64'd0);

        // Full operation against a chain preloaded with 0x0F3
        tick();
        env_val = 9'h0F3; env_load = 1'b1;
        tick();
        env_load = 1'b0;
        tick();
        run_op(9'h1A5, 1'b0, 1'b0, 0, lat, ncap, nsh, nupd, seq);
        check("full_latency", 64'(lat), 64'd12);
        check("full_capture_cycles", 64'(ncap), 64'd1);
        check("full_shift_cycles", 64'(nsh), 64'd9);
        check("full_update_cycles", 64'(nupd), 64'd1);
        check("full_wpsi_seq", 64'(seq), 64'h1A5);
        check("full_result", 64'(result), 64'h0F3);
        check("full_chain", 64'(chain), 64'h1A5);

        // Both phases skipped
        repeat (3) tick();
        run_op(9'h0C3, 1'b1, 1'b1, 0, lat, ncap, nsh, nupd, seq);
        check("skip_latency", 64'(lat), 64'd10);
        check("skip_capture_cycles", 64'(ncap), 64'd0);
        check("skip_update_cycles", 64'(nupd), 64'd0);
        check("skip_shift_cycles", 64'(nsh), 64'd9);
        check("skip_result", 64'(result), 64'h1A5);

        // Second start during SHIFT is ignored
        repeat (3) tick();
        run_op(9'h155, 1'b0, 1'b0, 1, lat, ncap, nsh, nupd, seq);
        check("ignore_latency", 64'(lat), 64'd12);
        check("ignore_wpsi_seq", 64'(seq), 64'h155);
        check("ignore_result", 64'(result), 64'h0C3);
        cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (done) cnt++;
        end
        check("ignore_extra_done", 64'(cnt), 64'd0);

        // RESET during the 4th SHIFT cycle
        tick();
        run_op(9'h0AA, 1'b0, 1'b0, 2, lat, ncap, nsh, nupd, seq);
        @(negedge CLK);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        RESET = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge CLK);
            if (done || !hold_inputs) cnt++;
        end
        check("rst_no_update_or_done", 64'(cnt), 64'd0);

        // start held high: one IDLE cycle between done and next capture
        tick();
        pat_in = 9'h13C; skip_capture = 1'b0; skip_update = 1'b0; start = 1'b1;
        t_done = -1; t_cap = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if (done && t_done < 0) t_done = n;
            if (capture_en && t_done >= 0 && t_cap < 0) t_cap = n;
        end
        check("b2b_found_done", 64'(t_done >= 0), 64'd1);
        check("b2b_gap", 64'(t_cap - t_done), 64'd2);
        start = 1'b0;
        repeat (20) tick();

        // Randomized traffic including mid-operation resets
        for (int c = 0; c < 1500; c++) begin
            tick();
            start        = ($urandom_range(0, 2) == 0);
            pat_in       = N'($urandom);
            skip_capture = $urandom_range(0, 1) == 1;
            skip_update  = $urandom_range(0, 1) == 1;
            RESET        = ($urandom_range(0, 149) == 0);
        end
        tick();
        RESET = 1'b0; start = 1'b0;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
